// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register-file write port between the pipeline writeback (WB),
// the SIMD FIR unit and the debug host. WB has absolute priority; SIMD and
// debug share the leftover slots round-robin. A per-requester wait counter
// forces a pipeline stall so a starving secondary always gets a slot.
// Optional feature macro: WARB_STATS_EN adds transfer/stall statistics ports.
module regfile_write_arbiter #(
  parameter int MAX_WAIT = 8,   // legal range 1..255
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_wa_i,
  input  logic [DATA_W-1:0] wb_wd_i,
  input  logic              simd_valid_i,
  output logic              simd_ready_o,
  input  logic [4:0]        simd_wa_i,
  input  logic [DATA_W-1:0] simd_wd_i,
  input  logic              dbg_valid_i,
  output logic              dbg_ready_o,
  input  logic [4:0]        dbg_wa_i,
  input  logic [DATA_W-1:0] dbg_wd_i,
`ifdef WARB_STATS_EN
  output logic [31:0]       stat_simd_o,
  output logic [31:0]       stat_dbg_o,
  output logic [31:0]       stat_stall_o,
`endif
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic [4:0]        WA_o,
  output logic [DATA_W-1:0] WD_o
);

  typedef enum logic [1:0] {
    S_NORMAL    = 2'd0,   // WB first, secondaries round-robin
    S_STALL_REQ = 2'd1,   // stall raised, draining in-flight WB writes
    S_FORCED    = 2'd2    // one slot reserved for a starving secondary
  } state_t;

  typedef enum logic {
    RR_SIMD = 1'b0,
    RR_DBG  = 1'b1
  } rr_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  // Registers 0 and 30 are never written; such writes are dropped here.
  function automatic logic is_discard(input logic [4:0] addr);
    return (addr == 5'd0) || (addr == 5'd30);
  endfunction

  state_t            state, state_nxt;
  rr_t               rr_ptr;
  logic [7:0]        simd_wait, dbg_wait;
  logic [7:0]        simd_wait_nxt, dbg_wait_nxt;
  logic              simd_grant, dbg_grant, rr_toggle, wb_pass;
  logic              wb_real, simd_starve, dbg_starve, any_max;
  logic              wr_en;
  logic [4:0]        wr_wa;
  logic [DATA_W-1:0] wr_wd;

  assign wb_real      = wb_we_i && !is_discard(wb_wa_i);
  assign simd_starve  = simd_valid_i && (simd_wait == MAX_CNT);
  assign dbg_starve   = dbg_valid_i && (dbg_wait == MAX_CNT);
  assign simd_ready_o = simd_grant;
  assign dbg_ready_o  = dbg_grant;

  // Grant selection, wait-counter update and next-state decision.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_nxt     = state;
    simd_grant    = 1'b0;
    dbg_grant     = 1'b0;
    rr_toggle     = 1'b0;
    wb_pass       = 1'b0;
    simd_wait_nxt = 8'd0;
    dbg_wait_nxt  = 8'd0;
    any_max       = 1'b0;

    unique case (state)
      S_NORMAL: begin
        if (wb_real) begin
          wb_pass = 1'b1;
        end else if (simd_valid_i && dbg_valid_i) begin
          simd_grant = (rr_ptr == RR_SIMD);
          dbg_grant  = (rr_ptr == RR_DBG);
          rr_toggle  = 1'b1;
        end else begin
          simd_grant = simd_valid_i;
          dbg_grant  = dbg_valid_i;
        end
      end
      S_STALL_REQ: begin
        wb_pass = wb_real;
      end
      S_FORCED: begin
        // Any WB write here breaks the stall contract and is dropped.
        if (simd_starve && dbg_starve) begin
          simd_grant = (rr_ptr == RR_SIMD);
          dbg_grant  = (rr_ptr == RR_DBG);
          rr_toggle  = 1'b1;
        end else begin
          simd_grant = simd_starve;
          dbg_grant  = dbg_starve;
        end
      end
      default: ;
    endcase

    // A counter tracks consecutive cycles spent valid but not accepted.
    if (simd_valid_i && !simd_grant)
      simd_wait_nxt = (simd_wait == MAX_CNT) ? MAX_CNT : simd_wait + 8'd1;
    if (dbg_valid_i && !dbg_grant)
      dbg_wait_nxt = (dbg_wait == MAX_CNT) ? MAX_CNT : dbg_wait + 8'd1;
    any_max = (simd_wait_nxt == MAX_CNT) || (dbg_wait_nxt == MAX_CNT);

    unique case (state)
      S_NORMAL:    state_nxt = any_max ? S_STALL_REQ : S_NORMAL;
      S_STALL_REQ: state_nxt = wb_real ? S_STALL_REQ : S_FORCED;
      S_FORCED:    state_nxt = any_max ? S_STALL_REQ : S_NORMAL;
      default:     state_nxt = S_NORMAL;
    endcase
  end

  // Select the write that will be presented to the register file next cycle.
  always_comb begin
    wr_en = 1'b0;
    wr_wa = wb_wa_i;
    wr_wd = wb_wd_i;
    if (simd_grant) begin
      wr_en = !is_discard(simd_wa_i);
      wr_wa = simd_wa_i;
      wr_wd = simd_wd_i;
    end else if (dbg_grant) begin
      wr_en = !is_discard(dbg_wa_i);
      wr_wa = dbg_wa_i;
      wr_wd = dbg_wd_i;
    end else if (wb_pass) begin
      wr_en = 1'b1;
    end
  end

  // Arbiter state: FSM, round-robin pointer and wait counters.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments make every register sample the same
    // pre-edge values, independent of statement order.
    if (reset) begin
      state     <= S_NORMAL;
      rr_ptr    <= RR_SIMD;
      simd_wait <= 8'd0;
      dbg_wait  <= 8'd0;
    end else begin
      state     <= state_nxt;
      simd_wait <= simd_wait_nxt;
      dbg_wait  <= dbg_wait_nxt;
      if (rr_toggle)
        rr_ptr <= (rr_ptr == RR_SIMD) ? RR_DBG : RR_SIMD;
    end
  end

  // Registered write port and stall; stall stays up one cycle past the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_o    <= 1'b0;
      RegWrite_o <= 1'b0;
      WA_o       <= 5'd0;
      WD_o       <= '0;
    end else begin
      stall_o    <= (state != S_NORMAL) || (state_nxt != S_NORMAL);
      RegWrite_o <= wr_en;
      if (wr_en) begin
        WA_o <= wr_wa;
        WD_o <= wr_wd;
      end
    end
  end

`ifdef WARB_STATS_EN
  // Statistics: useful secondary transfers and stalled cycles, wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_simd_o  <= 32'd0;
      stat_dbg_o   <= 32'd0;
      stat_stall_o <= 32'd0;
    end else begin
      if (simd_grant && !is_discard(simd_wa_i)) stat_simd_o <= stat_simd_o + 32'd1;
      if (dbg_grant && !is_discard(dbg_wa_i))   stat_dbg_o  <= stat_dbg_o + 32'd1;
      if (stall_o)                              stat_stall_o <= stat_stall_o + 32'd1;
    end
  end
`endif

  // A WB write must never reach the arbiter while a forced slot is running.
  wb_in_forced: assert property (@(posedge clk) disable iff (reset)
    !(state == S_FORCED && wb_real));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed vector table, hand-written
// starvation/reset sequences, then random traffic against a reference model.
module tb_regfile_write_arbiter;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we_i;
  logic [4:0]  wb_wa_i;
  logic [31:0] wb_wd_i;
  logic        simd_valid_i, simd_ready_o;
  logic [4:0]  simd_wa_i;
  logic [31:0] simd_wd_i;
  logic        dbg_valid_i, dbg_ready_o;
  logic [4:0]  dbg_wa_i;
  logic [31:0] dbg_wd_i;
  logic        stall_o, RegWrite_o;
  logic [4:0]  WA_o;
  logic [31:0] WD_o;
`ifdef WARB_STATS_EN
  logic [31:0] stat_simd_o, stat_dbg_o, stat_stall_o;
  int          m_ss, m_sd, m_st;
`endif

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(.MAX_WAIT(MAXW), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we_i      (wb_we_i),
    .wb_wa_i      (wb_wa_i),
    .wb_wd_i      (wb_wd_i),
    .simd_valid_i (simd_valid_i),
    .simd_ready_o (simd_ready_o),
    .simd_wa_i    (simd_wa_i),
    .simd_wd_i    (simd_wd_i),
    .dbg_valid_i  (dbg_valid_i),
    .dbg_ready_o  (dbg_ready_o),
    .dbg_wa_i     (dbg_wa_i),
    .dbg_wd_i     (dbg_wd_i),
`ifdef WARB_STATS_EN
    .stat_simd_o  (stat_simd_o),
    .stat_dbg_o   (stat_dbg_o),
    .stat_stall_o (stat_stall_o),
`endif
    .stall_o      (stall_o),
    .RegWrite_o   (RegWrite_o),
    .WA_o         (WA_o),
    .WD_o         (WD_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        sv;
    logic [4:0]  swa;
    logic [31:0] swd;
    logic        dv;
    logic [4:0]  dwa;
    logic [31:0] dwd;
    logic        e_sr;
    logic        e_dr;
    logic        e_stall;
    logic        e_rw;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic sv, input logic [4:0] swa, input logic [31:0] swd,
                        input logic dv, input logic [4:0] dwa, input logic [31:0] dwd);
    wb_we_i = we;  wb_wa_i = wa;  wb_wd_i = wd;
    simd_valid_i = sv; simd_wa_i = swa; simd_wd_i = swd;
    dbg_valid_i = dv;  dbg_wa_i = dwa;  dbg_wd_i = dwd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  // Both secondaries starve behind a busy WB; optionally reset mid-FORCED.
  task automatic run_both(input bit mid_reset);
    do_reset();
    for (int k = 0; k < MAXW; k++) begin
      set_in(1, 5'(k + 1), 32'(k), 1, 5'd7, 32'h77, 1, 5'd9, 32'h99);
      @(negedge clk);
      check($sformatf("both wait%0d simd_ready", k), simd_ready_o, 0);
      check($sformatf("both wait%0d dbg_ready", k), dbg_ready_o, 0);
      step();
    end
    wb_we_i = 1'b0;
    @(negedge clk);
    check("both stall_req stall", stall_o, 1);
    check("both stall_req simd_ready", simd_ready_o, 0);
    step();
    @(negedge clk);
    check("both forced1 simd_ready", simd_ready_o, 1);
    check("both forced1 dbg_ready", dbg_ready_o, 0);
    check("both forced1 stall", stall_o, 1);
    step();
    simd_valid_i = 1'b0;
    @(negedge clk);
    check("both gap dbg_ready", dbg_ready_o, 0);
    check("both gap stall", stall_o, 1);
    check("both gap RegWrite", RegWrite_o, 1);
    check("both gap WA", WA_o, 7);
    step();
    @(negedge clk);
    check("both forced2 dbg_ready", dbg_ready_o, 1);
    check("both forced2 stall", stall_o, 1);
    if (mid_reset) begin
      #1 reset = 1'b1;
      #1;
      check("reset stall", stall_o, 0);
      check("reset RegWrite", RegWrite_o, 0);
      check("reset WA", WA_o, 0);
      check("reset WD", WD_o, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step();
      set_in(0, 0, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
      @(negedge clk);
      check("post reset simd_ready", simd_ready_o, 1);
      check("post reset dbg_ready", dbg_ready_o, 0);
      check("post reset stall", stall_o, 0);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("post reset RegWrite", RegWrite_o, 1);
      check("post reset WA", WA_o, 3);
      check("post reset stall2", stall_o, 0);
      step();
    end else begin
      step();
      dbg_valid_i = 1'b0;
      @(negedge clk);
      check("both dbg RegWrite", RegWrite_o, 1);
      check("both dbg WA", WA_o, 9);
      check("both dbg WD", WD_o, 32'h99);
      check("both dbg stall", stall_o, 1);
      step();
      @(negedge clk);
      check("both end stall", stall_o, 0);
      step();
    end
  endtask

  // Reference model: state of the arbitration rules, not of the RTL.
  int          m_mode;     // 0 normal, 1 stall requested, 2 forced slot
  int          m_wait[2];  // consecutive unserved cycles per secondary
  int          m_rr;       // 0 SIMD next, 1 debug next
  bit          m_sr, m_dr;
  bit          exp_stall, exp_rw;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;

  function automatic bit discard(input logic [4:0] a);
    return (a == 5'd0) || (a == 5'd30);
  endfunction

  task automatic model_step();
    bit          v[2];
    logic [4:0]  a[2];
    logic [31:0] d[2];
    bit          starving[2];
    bit          wb_occ, any_max;
    int          g, nm;
    int          nw[2];
    v[0] = simd_valid_i; a[0] = simd_wa_i; d[0] = simd_wd_i;
    v[1] = dbg_valid_i;  a[1] = dbg_wa_i;  d[1] = dbg_wd_i;
    starving[0] = 0; starving[1] = 0;
    wb_occ = wb_we_i && !discard(wb_wa_i);
    g = -1;
    if (m_mode == 0 && !wb_occ) begin
      if (v[0] && v[1]) g = m_rr;
      else if (v[0])    g = 0;
      else if (v[1])    g = 1;
    end else if (m_mode == 2) begin
      for (int i = 0; i < 2; i++) starving[i] = v[i] && (m_wait[i] == MAXW);
      if (starving[0] && starving[1]) g = m_rr;
      else if (starving[0])           g = 0;
      else if (starving[1])           g = 1;
    end
    m_sr = (g == 0);
    m_dr = (g == 1);
`ifdef WARB_STATS_EN
    if (exp_stall) m_st++;
    if (g == 0 && !discard(a[0])) m_ss++;
    if (g == 1 && !discard(a[1])) m_sd++;
`endif
    if (g >= 0) begin
      exp_rw = !discard(a[g]);
      if (exp_rw) begin exp_wa = a[g]; exp_wd = d[g]; end
    end else if (wb_occ && m_mode != 2) begin
      exp_rw = 1; exp_wa = wb_wa_i; exp_wd = wb_wd_i;
    end else begin
      exp_rw = 0;
    end
    if (g >= 0 && v[0] && v[1] && (m_mode == 0 || (starving[0] && starving[1])))
      m_rr = 1 - m_rr;
    any_max = 0;
    for (int i = 0; i < 2; i++) begin
      nw[i] = (!v[i] || g == i) ? 0 : ((m_wait[i] + 1 > MAXW) ? MAXW : m_wait[i] + 1);
      if (nw[i] == MAXW) any_max = 1;
    end
    if (m_mode == 1) nm = wb_occ ? 1 : 2;
    else             nm = any_max ? 1 : 0;
    exp_stall = (m_mode != 0) || (nm != 0);
    m_mode = nm;
    m_wait = nw;
  endtask

  initial begin
    int busy;
    // Directed table: readys for this cycle, registered outputs of the last.
    vecs[0]  = '{1, 5, 32'hAAAA5555, 1, 9, 32'h99,  0, 0,  0,      0, 0, 0, 0, 0,  0};
    vecs[1]  = '{0, 0, 0,            1, 9, 32'h99,  0, 0,  0,      1, 0, 0, 1, 5,  32'hAAAA5555};
    vecs[2]  = '{0, 0, 0,            1, 3, 32'h11,  1, 4,  32'h22, 1, 0, 0, 1, 9,  32'h99};
    vecs[3]  = '{0, 0, 0,            1, 3, 32'h11,  1, 4,  32'h22, 0, 1, 0, 1, 3,  32'h11};
    vecs[4]  = '{0, 0, 0,            0, 0, 0,       1, 30, 32'hFF, 0, 1, 0, 1, 4,  32'h22};
    vecs[5]  = '{1, 0, 32'h1234,     1, 6, 32'h66,  0, 0,  0,      1, 0, 0, 0, 0,  0};
    vecs[6]  = '{0, 0, 0,            0, 0, 0,       0, 0,  0,      0, 0, 0, 1, 6,  32'h66};
    vecs[7]  = '{1, 30, 32'h5555,    1, 1, 32'h101, 1, 2,  32'h202,1, 0, 0, 0, 0,  0};
    vecs[8]  = '{1, 12, 32'hC0FFEE,  0, 0, 0,       1, 2,  32'h202,0, 0, 0, 1, 1,  32'h101};
    vecs[9]  = '{0, 0, 0,            0, 0, 0,       1, 2,  32'h202,0, 1, 0, 1, 12, 32'hC0FFEE};
    vecs[10] = '{0, 0, 0,            0, 0, 0,       0, 0,  0,      0, 0, 0, 1, 2,  32'h202};
    vecs[11] = '{0, 0, 0,            0, 0, 0,       0, 0,  0,      0, 0, 0, 0, 0,  0};

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset stall", stall_o, 0);
    check("reset RegWrite", RegWrite_o, 0);
    check("reset WA", WA_o, 0);
    check("reset WD", WD_o, 0);
    check("reset simd_ready", simd_ready_o, 0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].wb_we, vecs[i].wb_wa, vecs[i].wb_wd, vecs[i].sv, vecs[i].swa,
             vecs[i].swd, vecs[i].dv, vecs[i].dwa, vecs[i].dwd);
      @(negedge clk);
      check($sformatf("vec%0d simd_ready", i), simd_ready_o, vecs[i].e_sr);
      check($sformatf("vec%0d dbg_ready", i), dbg_ready_o, vecs[i].e_dr);
      check($sformatf("vec%0d stall", i), stall_o, vecs[i].e_stall);
      check($sformatf("vec%0d RegWrite", i), RegWrite_o, vecs[i].e_rw);
      if (vecs[i].e_rw) begin
        check($sformatf("vec%0d WA", i), WA_o, vecs[i].e_wa);
        check($sformatf("vec%0d WD", i), WD_o, vecs[i].e_wd);
      end
      step();
    end

    // Single SIMD starvation behind a continuously busy WB.
    do_reset();
    for (int k = 0; k < MAXW; k++) begin
      set_in(1, 5'(k + 1), 32'(k), 1, 5'd7, 32'h77, 0, 0, 0);
      @(negedge clk);
      check($sformatf("starve wait%0d simd_ready", k), simd_ready_o, 0);
      check($sformatf("starve wait%0d stall", k), stall_o, 0);
      step();
    end
    wb_we_i = 1'b0;
    @(negedge clk);
    check("starve stall rise", stall_o, 1);
    check("starve stall_req simd_ready", simd_ready_o, 0);
    check("starve last wb RegWrite", RegWrite_o, 1);
    check("starve last wb WA", WA_o, 8);
    step();
    @(negedge clk);
    check("starve forced simd_ready", simd_ready_o, 1);
    check("starve forced stall", stall_o, 1);
    step();
    simd_valid_i = 1'b0;
    @(negedge clk);
    check("starve RegWrite", RegWrite_o, 1);
    check("starve WA", WA_o, 7);
    check("starve WD", WD_o, 32'h77);
    check("starve stall hold", stall_o, 1);
    step();
    @(negedge clk);
    check("starve stall fall", stall_o, 0);
    check("starve RegWrite idle", RegWrite_o, 0);
    step();

    run_both(1'b0);
    run_both(1'b1);

    // Random traffic against the reference model.
    do_reset();
    m_mode = 0; m_wait[0] = 0; m_wait[1] = 0; m_rr = 0;
    m_sr = 0; m_dr = 0; exp_stall = 0; exp_rw = 0; exp_wa = 0; exp_wd = 0;
`ifdef WARB_STATS_EN
    m_ss = 0; m_sd = 0; m_st = 0;
`endif
    busy = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       busy = 20;
          1:       busy = 60;
          default: busy = 95;
        endcase
      end
      if (!(simd_valid_i && !m_sr)) begin
        simd_valid_i = ($urandom_range(0, 99) < 45);
        simd_wa_i    = 5'($urandom_range(0, 31));
        simd_wd_i    = $urandom;
      end else if ($urandom_range(0, 99) < 3) begin
        simd_valid_i = 1'b0;
      end
      if (!(dbg_valid_i && !m_dr)) begin
        dbg_valid_i = ($urandom_range(0, 99) < 45);
        dbg_wa_i    = 5'($urandom_range(0, 31));
        dbg_wd_i    = $urandom;
      end else if ($urandom_range(0, 99) < 3) begin
        dbg_valid_i = 1'b0;
      end
      wb_we_i = (m_mode == 2) ? 1'b0 : ($urandom_range(0, 99) < busy);
      wb_wa_i = 5'($urandom_range(0, 31));
      wb_wd_i = $urandom;
      @(negedge clk);
      check($sformatf("rnd%0d stall", n), stall_o, exp_stall);
      check($sformatf("rnd%0d RegWrite", n), RegWrite_o, exp_rw);
      if (exp_rw) begin
        check($sformatf("rnd%0d WA", n), WA_o, exp_wa);
        check($sformatf("rnd%0d WD", n), WD_o, exp_wd);
      end
      model_step();
      check($sformatf("rnd%0d simd_ready", n), simd_ready_o, m_sr);
      check($sformatf("rnd%0d dbg_ready", n), dbg_ready_o, m_dr);
      step();
    end
`ifdef WARB_STATS_EN
    @(negedge clk);
    check("stat simd", stat_simd_o, m_ss);
    check("stat dbg", stat_dbg_o, m_sd);
    check("stat stall", stat_stall_o, m_st);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
